// File: rtl/data_mem_lsu.sv
// Handshaked load/store data memory: size/sign decode, byte-lane merge, fault detection, LATENCY wait states.
// Latency: good access responds LATENCY+2 cycles after accept, faults respond 1 cycle after accept.
// Backpressure: one request in flight; req_ready low until the response handshake completes.
module data_mem_lsu #(
  parameter int                XLEN      = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                LATENCY   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_ctr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [1:0]        resp_cause
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $fatal(1, "data_mem_lsu: XLEN must be 32 or 64");
    end
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_lat
      $fatal(1, "data_mem_lsu: LATENCY must be 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT, RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            we_q;
  logic [2:0]      ctr_q;
  logic [XLEN-1:0] wdata_q;
  logic [OFF_W-1:0] off_q;
  logic [1:0]      req_cause;
  logic [2:0]      align_mask;

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_W+1)'(DEPTH * NB);
  logic [IDX_W-1:0] idx_q;
  logic [XLEN-1:0]  mem [DEPTH];

  // Shift the addressed lanes down, then extend to XLEN according to ctr.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] word,
                                               input logic [OFF_W-1:0] off,
                                               input logic [2:0] ctr);
    logic [XLEN-1:0] sh;
    sh = word >> {off, 3'b000};
    case (ctr)
      3'b000:  load_ext = XLEN'($signed(sh[7:0]));
      3'b001:  load_ext = XLEN'($signed(sh[15:0]));
      3'b010:  load_ext = XLEN'($signed(sh[31:0]));
      3'b100:  load_ext = XLEN'(sh[7:0]);
      3'b101:  load_ext = XLEN'(sh[15:0]);
      3'b110:  load_ext = XLEN'(sh[31:0]);
      default: load_ext = sh;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] wdata,
                                                  input logic [OFF_W-1:0] off,
                                                  input logic [2:0] ctr);
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wsh;
    logic [XLEN-1:0] bm;
    case (ctr[1:0])
      2'd0:    be = NB'(1);
      2'd1:    be = NB'(3);
      2'd2:    be = NB'(15);
      default: be = '1;
    endcase
    be  = be << off;
    wsh = wdata << {off, 3'b000};
    for (int i = 0; i < NB; i++) bm[i*8 +: 8] = {8{be[i]}};
    store_merge = (old & ~bm) | (wsh & bm);
  endfunction

  // Illegal ctr outranks misalignment, which outranks range.
  always_comb begin
    align_mask = 3'b000;
    case (req_ctr[1:0])
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    req_cause = 2'b00;
    if (req_ctr == 3'b111 || (XLEN == 32 && (req_ctr == 3'b011 || req_ctr == 3'b110)))
      req_cause = 2'b11;
    else if ((req_addr[2:0] & align_mask) != 3'b000)
      req_cause = 2'b01;
    else if (req_addr < BASE_ADDR || {1'b0, req_addr} >= LIMIT)
      req_cause = 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      resp_cause <= 2'b00;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      ctr_q      <= 3'b000;
      wdata_q    <= '0;
      off_q      <= '0;
      idx_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            ctr_q     <= req_ctr;
            wdata_q   <= req_wdata;
            off_q     <= req_addr[OFF_W-1:0];
            idx_q     <= IDX_W'((req_addr - BASE_ADDR) >> OFF_W);
            if (req_cause != 2'b00) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_cause <= req_cause;
              resp_rdata <= '0;
            end else if (LATENCY == 0) begin
              state <= COMMIT;
            end else begin
              state <= WAIT;
              cnt   <= LAT_CNT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= COMMIT;
        end
        COMMIT: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_cause <= 2'b00;
          resp_rdata <= we_q ? '0 : load_ext(mem[idx_q], off_q, ctr_q);
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is not reset; an async reset drops state out of COMMIT before the edge, so no write.
  always_ff @(posedge clk) begin
    if (state == COMMIT && we_q)
      mem[idx_q] <= store_merge(mem[idx_q], wdata_q, off_q, ctr_q);
  end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Parametrised, handshaked data memory for the CPU load/store path; successor to the single-cycle data memory.
- Accepts one request at a time over a valid/ready channel and applies a programmable number of wait states.
- Performs byte-lane extraction/merge with sign/zero extension, flags misaligned, out-of-range and illegal-size accesses, and returns a response over a second valid/ready channel.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- ADDR_W, 32, address width.
- DEPTH, 1024, number of XLEN-bit words in internal storage.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 0, extra wait cycles before the access commits; range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_ctr  in  3  size/sign code: 000 b, 001 h, 010 w, 011 d (XLEN=64 only), 100 bu, 101 hu, 110 wu (XLEN=64 only).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  access faulted.
- resp_cause  out  2  01 misaligned, 10 out of range, 11 illegal ctr, 00 ok.

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; resp_cause=00; wait counter=0. Storage contents are not reset.
- States:
  - IDLE: req_ready=1 only here. On req_valid&req_ready, latch we/ctr/addr/wdata and check the request.
    - Fault → RESP next cycle.
    - Otherwise, with LATENCY=0 → COMMIT.
    - Otherwise → WAIT, with counter=LATENCY.
  - WAIT: counter decrements each cycle; at counter==1 → COMMIT.
  - COMMIT: a single cycle. A load reads the word; a store writes the merged word on the exiting edge. → RESP.
- Latency: resp_valid rises LATENCY+2 cycles after the accept edge for good accesses and 1 cycle after for faults.
- RESP:
  - resp_valid=1; resp_* held stable until resp_ready.
  - On resp_valid&resp_ready → IDLE; resp_valid=0 the next cycle.
  - No same-cycle re-accept: minimum request spacing is one idle cycle.
- Fault priority is illegal ctr > misaligned > out of range.
  - Illegal ctr: 111, or 011/110 when XLEN=32.
  - Misaligned: the address is not a multiple of the access size.
  - Out of range: addr < BASE_ADDR or addr ≥ BASE_ADDR + DEPTH*XLEN/8.
  - A faulted store never modifies storage.
- Word index = (addr−BASE_ADDR) >> log2(XLEN/8); byte offset = low log2(XLEN/8) address bits.
- Load: shift the word right by offset*8, then take the access width. ctr[2]=0 sign-extends (except w on XLEN=32 and d, which take the full width); ctr[2]=1 zero-extends.
- Store: the byte enable covers the access width at the offset. Only enabled bytes are replaced with the corresponding low bytes of wdata, shifted to the offset; other bytes are preserved.
- Reset mid-operation (any state): abort immediately to IDLE. A store whose COMMIT edge has not occurred is not written.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: DATAMEM_DPI_EN.
- Defined:
  - Internal array removed.
  - COMMIT calls the pmem_read DPI function on the word-aligned address for loads.
  - COMMIT calls the pmem_write DPI function for stores, passing the unmodified address, the wdata, and a len of 1/2/4 equal to the access size.
  - Out-of-range check disabled (cause 10 never reported).
  - XLEN must be 32; any other value is a fatal elaboration error.
- Undefined: internal DEPTH-word array as described above.

Test Plan:
- LATENCY=0: store w 0xDEADBEEF @0x80000000, then load w → resp_rdata=0xDEADBEEF, err=0; resp_valid rises 2 cycles after each accept.
- After the above: store b 0x5A @0x80000001, then load bu @0x80000001 → 0x0000005A; load w → 0xDEAD5AEF; load b @0x80000003 → 0xFFFFFFDE.
- Load h @0x80000002 → 0xFFFFDEAD; load hu → 0x0000DEAD. Load w @0x80000002 → err=1, cause=01, rdata=0, 1-cycle response.
- Store to 0x80001000 with DEPTH=1024 → err=1, cause=10, storage unchanged. ctr=111 → cause=11. Misaligned out-of-range address → cause=01.
- LATENCY=3 with resp_ready held low for 5 cycles:
  - resp_valid rises 5 cycles after accept.
  - rdata stays stable while resp_ready is low.
  - req_ready=0 throughout.
  - req_ready=1 the cycle after the handshake.
- LATENCY=3: assert rst in WAIT during a store of 0x12345678 @0x80000010 → outputs return to reset values at once; a subsequent load w @0x80000010 returns the prior contents.
